// File: rtl/cp_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cp_pipe_ctrl
//  Purpose  : Full/empty sequencer for a DEPTH-stage cp_latch chain, issuing
//             per-stage capture (c) and pass (p) with valid/ready handshakes.
//  Options  : define CP_STALL_CNT_EN to add the saturating stall_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module cp_pipe_ctrl #(
    parameter  int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] c,
    output logic [DEPTH-1:0] p,
    output logic [OCC_W-1:0] occupancy
`ifdef CP_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    logic [DEPTH-1:0] r_full;
    logic [OCC_W-1:0] r_occ;
    logic [DEPTH-1:0] w_src;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_mv;
    logic [DEPTH-1:0] w_full_nxt;
    logic             w_clear;
    logic             w_accept;
    logic             w_take;

    assign w_clear = rst | flush;

    generate
        if (DEPTH == 1) begin : g_src_single
            assign w_src = in_valid;
        end else begin : g_src_chain
            assign w_src = {r_full[DEPTH-2:0], in_valid};
        end
    endgenerate

    // Resolve advance from the consumer end back toward the producer so a
    // bubble freed at the tail propagates to stage 0 in the same cycle.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = r_full[DEPTH-1] & out_ready;
        for (int i = DEPTH - 1; i > 0; i--) begin
            w_adv[i-1] = w_src[i] & (~r_full[i] | w_adv[i]);
        end
        w_mv       = w_src & (~r_full | w_adv);
        w_full_nxt = w_mv | (r_full & ~w_adv);
    end

    assign c         = w_mv & {DEPTH{~w_clear}};
    assign p         = r_full;
    assign in_ready  = (~r_full[0] | w_adv[0]) & ~w_clear;
    assign out_valid = r_full[DEPTH-1];
    assign occupancy = r_occ;

    assign w_accept  = in_valid & in_ready;
    assign w_take    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_full <= '0;
            r_occ  <= '0;
        end else begin
            r_full <= w_full_nxt;
            case ({w_accept, w_take})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef CP_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Only rst clears the counter; flush intentionally leaves it running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (out_valid & ~out_ready & (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cp_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp_pipe_ctrl
//  Purpose  : Self-checking bench for cp_pipe_ctrl (DEPTH=4) with a modelled
//             latch datapath and word scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cp_pipe_ctrl;
    localparam int DEPTH = 4;
    localparam int OCC_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [DEPTH-1:0] c;
    logic [DEPTH-1:0] p;
    logic [OCC_W-1:0] occupancy;
`ifdef CP_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    cp_pipe_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .p         (p),
        .occupancy (occupancy)
`ifdef CP_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             r, f, v, o;
        logic             ir, ov;
        logic [DEPTH-1:0] ec, ep;
        logic [OCC_W-1:0] eo;
    } vec_t;

    vec_t        vecs[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          mcnt    = 0;
    logic [15:0] in_data = 16'h1000;
    logic [15:0] lat[DEPTH];
    logic [15:0] sb[$];

    function automatic void add(input logic r, f, v, o, ir, ov,
                                input logic [DEPTH-1:0] ec, ep,
                                input logic [OCC_W-1:0] eo);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.o = o; t.ir = ir; t.ov = ov;
        t.ec = ec; t.ep = ep; t.eo = eo;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic o);
        rst = r; flush = f; in_valid = v; out_ready = o;
        in_data = in_data + 16'h0001;
    endtask

    // Called at the negedge: checks the handshake model, runs the scoreboard
    // and advances the bench copy of the latch chain using the DUT strobes.
    task automatic book();
        logic    exp_ir;
        logic [15:0] w;
        exp_ir = !(rst || flush) && !(mcnt == DEPTH && !out_ready);
        check("in_ready_model", {31'd0, in_ready}, {31'd0, exp_ir});
        check("occupancy_model", {29'd0, occupancy}, mcnt);
        if (rst || flush) begin
            check("c_clear", {28'd0, c}, 32'd0);
            sb.delete();
            mcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL take_empty: got out_valid=1 expected no word pending");
                end else begin
                    w = sb.pop_front();
                    check("data_order", {16'd0, lat[DEPTH-1]}, {16'd0, w});
                    mcnt--;
                end
            end
            if (in_valid && exp_ir) begin
                sb.push_back(in_data);
                mcnt++;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (c[i]) begin
                if (i == 0) lat[0] = in_data;
                else        lat[i] = lat[i-1];
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset / latency
        add(1,0,1,0, 0,0, 4'b0000,4'b0000,3'd0);
        add(1,0,1,0, 0,0, 4'b0000,4'b0000,3'd0);
        add(0,0,0,0, 1,0, 4'b0000,4'b0000,3'd0);
        add(0,0,1,1, 1,0, 4'b0001,4'b0000,3'd0);
        add(0,0,0,1, 1,0, 4'b0010,4'b0001,3'd1);
        add(0,0,0,1, 1,0, 4'b0100,4'b0010,3'd1);
        add(0,0,0,1, 1,0, 4'b1000,4'b0100,3'd1);
        add(0,0,0,1, 1,1, 4'b0000,4'b1000,3'd1);
        add(0,0,0,1, 1,0, 4'b0000,4'b0000,3'd0);
        // fill / stall
        add(0,0,1,0, 1,0, 4'b0001,4'b0000,3'd0);
        add(0,0,1,0, 1,0, 4'b0011,4'b0001,3'd1);
        add(0,0,1,0, 1,0, 4'b0111,4'b0011,3'd2);
        add(0,0,1,0, 1,0, 4'b1111,4'b0111,3'd3);
        add(0,0,1,0, 0,1, 4'b0000,4'b1111,3'd4);
        add(0,0,1,0, 0,1, 4'b0000,4'b1111,3'd4);
        // streaming from full
        for (int k = 0; k < 8; k++) add(0,0,1,1, 1,1, 4'b1111,4'b1111,3'd4);
        // drain one, then flush at occupancy 3
        add(0,0,0,1, 1,1, 4'b1110,4'b1111,3'd4);
        add(0,1,1,0, 0,1, 4'b0000,4'b1110,3'd3);
        add(0,0,0,1, 1,0, 4'b0000,4'b0000,3'd0);
        add(0,0,0,0, 1,0, 4'b0000,4'b0000,3'd0);
        // reset mid-operation
        add(0,0,1,0, 1,0, 4'b0001,4'b0000,3'd0);
        add(0,0,1,0, 1,0, 4'b0011,4'b0001,3'd1);
        add(1,0,1,1, 0,0, 4'b0000,4'b0011,3'd2);
        add(0,0,0,0, 1,0, 4'b0000,4'b0000,3'd0);

        for (int i = 0; i < DEPTH; i++) lat[i] = 16'h0000;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        next_cycle();

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].f, vecs[k].v, vecs[k].o);
            @(negedge clk);
            check($sformatf("v%0d_in_ready", k), {31'd0, in_ready}, {31'd0, vecs[k].ir});
            check($sformatf("v%0d_out_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].ov});
            check($sformatf("v%0d_c", k), {28'd0, c}, {28'd0, vecs[k].ec});
            check($sformatf("v%0d_p", k), {28'd0, p}, {28'd0, vecs[k].ep});
            check($sformatf("v%0d_occ", k), {29'd0, occupancy}, {29'd0, vecs[k].eo});
            book();
            next_cycle();
        end

        // randomized traffic against the handshake model and scoreboard
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
            @(negedge clk);
            book();
            next_cycle();
        end

`ifdef CP_STALL_CNT_EN
        drive(1, 0, 0, 0); @(negedge clk); book(); next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0); @(negedge clk);
            check("stall_fill", {16'd0, stall_cnt}, 32'd0);
            book(); next_cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0); @(negedge clk); book(); next_cycle();
        end
        drive(0, 1, 0, 1); @(negedge clk);
        check("stall_10", {16'd0, stall_cnt}, 32'd10);
        book(); next_cycle();
        drive(0, 0, 0, 0); @(negedge clk);
        check("stall_after_flush", {16'd0, stall_cnt}, 32'd10);
        book(); next_cycle();
        drive(1, 0, 0, 0); @(negedge clk); book(); next_cycle();
        drive(0, 0, 0, 0); @(negedge clk);
        check("stall_after_rst", {16'd0, stall_cnt}, 32'd0);
        book(); next_cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
